// File: rtl/gent_constrained_rng.sv
// Multi-channel constrained-random value generator: per-channel policies served
// by bounded rejection sampling from a shared 32-bit Galois LFSR.
module gent_constrained_rng #(
    parameter int          WIDTH        = 16,
    parameter int          NUM_CHANNELS = 4,
    parameter int          MAX_TRIES    = 8,
    parameter logic [31:0] SEED         = 32'h0000_0001
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             cfg_we,
    input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [1:0]                                       cfg_mode,
    input  logic [WIDTH-1:0]                                 cfg_lo,
    input  logic [WIDTH-1:0]                                 cfg_hi,
    input  logic                                             seed_load,
    input  logic [31:0]                                      seed_value,
    input  logic                                             req_valid,
    output logic                                             req_ready,
    input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] req_chan,
    output logic                                             rsp_valid,
    input  logic                                             rsp_ready,
    output logic [WIDTH-1:0]                                 rsp_data,
    output logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] rsp_chan,
    output logic                                             rsp_fallback
);

    localparam int               CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int               TW    = $clog2(MAX_TRIES + 1);
    localparam logic [31:0]      POLY  = 32'h8020_0003;
    localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [TW-1:0]    LAST  = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    function automatic logic chan_ok(input logic [CW-1:0] c);
        return 32'(c) < 32'(NUM_CHANNELS);
    endfunction

    function automatic logic cand_ok(input logic [1:0] mode, input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
        logic ok;
        case (mode)
            2'd1:    ok = (c >= lo) && (c <= hi);
            2'd2:    ok = (c < lo) || (c > hi);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Exclude-range falls back to the nearest value just outside the window.
    function automatic logic [WIDTH-1:0] fallback_value(input logic [1:0] mode,
                                                        input logic [WIDTH-1:0] lo,
                                                        input logic [WIDTH-1:0] hi);
        logic [WIDTH-1:0] v;
        case (mode)
            2'd2: begin
                if (hi != MAXV) begin
                    v = hi + ONE;
                end else if (lo != '0) begin
                    v = lo - ONE;
                end else begin
                    v = '0;
                end
            end
            default: v = lo;
        endcase
        return v;
    endfunction

    state_t             state_r, state_next_s;
    logic [1:0]         mode_r [NUM_CHANNELS];
    logic [WIDTH-1:0]   lo_r   [NUM_CHANNELS];
    logic [WIDTH-1:0]   hi_r   [NUM_CHANNELS];
    logic [31:0]        lfsr_r;
    logic [1:0]         snap_mode_r;
    logic [WIDTH-1:0]   snap_lo_r, snap_hi_r;
    logic [CW-1:0]      chan_r;
    logic [TW-1:0]      tries_r;
    logic [WIDTH-1:0]   rsp_data_r;
    logic [CW-1:0]      rsp_chan_r;
    logic               rsp_fallback_r;
    logic [1:0]         req_mode_s;
    logic [WIDTH-1:0]   req_lo_s, req_hi_s, cand_s;
    logic               pass_s, last_s;

    assign cand_s = lfsr_r[WIDTH-1:0];
    assign pass_s = cand_ok(snap_mode_r, cand_s, snap_lo_r, snap_hi_r);
    assign last_s = (tries_r == LAST);

    // Policy lookup for the requesting channel; unknown channels act as uniform.
    always_comb begin
        req_mode_s = 2'd0;
        req_lo_s   = '0;
        req_hi_s   = '0;
        if (chan_ok(req_chan)) begin
            req_mode_s = mode_r[req_chan];
            req_lo_s   = lo_r[req_chan];
            req_hi_s   = hi_r[req_chan];
        end else begin
            req_mode_s = 2'd0;
        end
    end

    // Per-channel policy table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                mode_r[i] <= 2'd0;
                lo_r[i]   <= '0;
                hi_r[i]   <= '0;
            end
        end else if (cfg_we && chan_ok(cfg_chan)) begin
            mode_r[cfg_chan] <= cfg_mode;
            lo_r[cfg_chan]   <= cfg_lo;
            hi_r[cfg_chan]   <= cfg_hi;
        end
    end

    // LFSR: a seed load wins over stepping; fixed mode does not consume entropy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else if (seed_load) begin
            lfsr_r <= (seed_value == 32'h0000_0000) ? SEED : seed_value;
        end else if (state_r == SAMPLE && snap_mode_r != 2'd3) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = req_valid ? SAMPLE : IDLE;
            SAMPLE:  state_next_s = (pass_s || last_s) ? RESP : SAMPLE;
            RESP:    state_next_s = rsp_ready ? IDLE : RESP;
            default: state_next_s = IDLE;
        endcase
    end

    // Request snapshot, attempt counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_mode_r    <= 2'd0;
            snap_lo_r      <= '0;
            snap_hi_r      <= '0;
            chan_r         <= '0;
            tries_r        <= '0;
            rsp_data_r     <= '0;
            rsp_chan_r     <= '0;
            rsp_fallback_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tries_r <= '0;
                    if (req_valid) begin
                        snap_mode_r <= req_mode_s;
                        snap_lo_r   <= req_lo_s;
                        snap_hi_r   <= req_hi_s;
                        chan_r      <= req_chan;
                    end
                end
                SAMPLE: begin
                    tries_r <= tries_r + TW'(1);
                    if (pass_s) begin
                        rsp_data_r     <= (snap_mode_r == 2'd3) ? snap_lo_r : cand_s;
                        rsp_chan_r     <= chan_r;
                        rsp_fallback_r <= 1'b0;
                    end else if (last_s) begin
                        rsp_data_r     <= fallback_value(snap_mode_r, snap_lo_r, snap_hi_r);
                        rsp_chan_r     <= chan_r;
                        rsp_fallback_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        req_ready = (state_r == IDLE);
        rsp_valid = (state_r == RESP);
    end

    assign rsp_data     = rsp_data_r;
    assign rsp_chan     = rsp_chan_r;
    assign rsp_fallback = rsp_fallback_r;

endmodule

// File: doc/gent_constrained_rng.md
# gent_constrained_rng

Hardware constrained-random value generator for the `gent_randomization` domain. It is a parametrised, multi-channel policy engine: each channel holds a policy (uniform, range, exclude-range, fixed) and serves requests by rejection sampling from a shared 32-bit Galois LFSR. A bounded retry count guarantees termination with a deterministic fallback. It sits between stimulus sequencers and DUT-facing drivers in emulation/FPGA benches.

## Interface
- `WIDTH`, 16: output value width, 1..32; candidate = `lfsr[WIDTH-1:0]`.
- `NUM_CHANNELS`, 4: number of independent policy channels, ≥1.
- `MAX_TRIES`, 8: maximum sampling attempts per request, ≥1.
- `SEED`, 32'h0000_0001: LFSR reset value; also replaces a zero `seed_value`. Must be nonzero.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: write policy for channel `cfg_chan`.
- `cfg_chan` in $clog2(NUM_CHANNELS) (min 1): target channel.
- `cfg_mode` in 2: 0 uniform, 1 range, 2 exclude-range, 3 fixed.
- `cfg_lo`, `cfg_hi` in WIDTH: policy bounds, unsigned.
- `seed_load` in 1: load LFSR with `seed_value` (or `SEED` if zero).
- `seed_value` in 32: new seed.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_chan` in $clog2(NUM_CHANNELS): channel to sample.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out WIDTH: generated value.
- `rsp_chan` out $clog2(NUM_CHANNELS): channel of the response.
- `rsp_fallback` out 1: retries exhausted; `rsp_data` is the fallback value.

## Operation
- Reset: all channels mode 0, lo 0, hi 0; LFSR = `SEED`; FSM IDLE; `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_chan`=0, `rsp_fallback`=0.
- LFSR step: `b=lfsr[0]; lfsr=lfsr>>1; if b lfsr^=32'h8020_0003`. Steps only in SAMPLE, one step per SAMPLE cycle.
- FSM IDLE: `req_ready`=1. On `req_valid`, latch `req_chan` and snapshot its policy; tries=0; go to SAMPLE.
- FSM SAMPLE: `req_ready`=0. Evaluate candidate = current `lfsr[WIDTH-1:0]`; tries+1.
  - Mode 0: always passes. Mode 3: always passes; data=lo, no LFSR consumption.
  - Mode 1: pass iff lo ≤ cand ≤ hi. Mode 2: pass iff cand < lo or cand > hi.
  - Pass: latch data, `rsp_fallback`=0, go to RESP.
  - Fail on attempt MAX_TRIES: go to RESP with `rsp_fallback`=1. Fallback data: mode 1 gives lo. Mode 2 gives hi+1 if hi<max, else lo−1 if lo>0, else 0.
- FSM RESP: `rsp_valid`=1, outputs held stable until `rsp_ready`; then IDLE. Outputs keep their last values after handshake; only `rsp_valid` drops.
- Config writes are accepted in any state and take effect on the next accepted request. An in-flight request uses its snapshot. A write and a request on the same channel in the same cycle: the request sees the old policy.
- Range with lo>hi is unsatisfiable: all MAX_TRIES fail, fallback=lo. Exclude with lo=0 and hi=max is unsatisfiable: fallback data 0.
- `seed_load` in any state: the LFSR loads instead of stepping that cycle. A candidate evaluated in that cycle uses the pre-load value.
- `req_chan` ≥ NUM_CHANNELS: treated as mode 0.
- `cfg_chan` ≥ NUM_CHANNELS: the write is ignored.

## Timing
- Accept edge t. First SAMPLE evaluation happens in cycle t+1. `rsp_valid` rises at t+1+k, where k is the number of attempts (1..MAX_TRIES).
- Minimum latency 2 cycles (modes 0/3). Maximum MAX_TRIES+1 cycles.
- Throughput: one request per (latency+1) cycles with `rsp_ready` held high; RESP→IDLE costs one cycle.
- Reset asserted mid-SAMPLE or mid-RESP: outputs return immediately (asynchronously) to reset values. The pending request is dropped.

## Test plan
- Reset, then `SEED`=1, channel 0 mode 0, one request with `rsp_ready`=1 → `rsp_data`=0x0001 at t+2. A second request → 0x0003 (LFSR 0x8020_0003).
- Channel 2 mode 3, lo=0x1234 → `rsp_data`=0x1234, `rsp_chan`=2, `rsp_fallback`=0, latency 2. The LFSR is unchanged (next mode 0 request still returns the expected sequence value).
- Channel 1 mode 1, lo=hi=5, `SEED`=1 → after 8 SAMPLE cycles, `rsp_valid` at t+9 with data 5, fallback=1.
- Channel 3 mode 2, lo=0, hi=0xFFFF → fallback=1, data 0. With lo=0, hi=0xFFFE → data 0xFFFF in fallback, or any passing candidate equal to 0xFFFF.
- Hold `rsp_ready`=0 for 5 cycles in RESP → data/chan/fallback stable and `req_ready`=0 throughout. A cfg write to the active channel during SAMPLE does not change the result.
- `seed_load` with `seed_value`=0 → LFSR=`SEED`. Assert `rst` during SAMPLE → `rsp_valid`=0 and `req_ready`=1 immediately, and the LFSR sequence restarts at `SEED`.
